matmul_tile_sequencer: RTL and testbench

- Control FSM that walks the blocked loop nest for C = A x B, with A of size M x N and B of size N x P.
- Issues one-cycle start pulses to the block-fetch A, block-fetch B, block-multiply and block-accumulate units, and waits on their done strobes.
- Drives the tile coordinates, edge-tile extents and the accumulator-clear flag.
- Sits between the host start/done handshake and the tile datapath.

---
 rtl/matmul_tile_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: control FSM that walks the blocked loop nest of C = A x B
// (A is M x N, B is N x P). For each tile step it pulses fetch-A, fetch-B, multiply and
// accumulate in turn, waiting on each unit's done strobe, and drives the tile coordinates
// and edge-tile extents.
// Optional build macro MATMUL_SEQ_OVERLAP_EN: fetch-A and fetch-B are started together in
// a single FETCH state that waits for both done strobes in any order.
module matmul_tile_sequencer #(
    parameter int unsigned M     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned P     = 4,
    parameter int unsigned TJ    = 2,
    parameter int unsigned TK    = 2,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             fa_start,
    input  logic             fa_done,
    output logic             fb_start,
    input  logic             fb_done,
    output logic             mul_start,
    input  logic             mul_done,
    output logic             acc_start,
    input  logic             acc_done,
    output logic [IDX_W-1:0] row_i,
    output logic [IDX_W-1:0] red_r,
    output logic [IDX_W-1:0] col_l,
    output logic [IDX_W-1:0] rows_v,
    output logic [IDX_W-1:0] cols_v,
    output logic [IDX_W-1:0] red_v,
    output logic             acc_clear,
    output logic [IDX_W-1:0] step_cnt
);

    localparam logic [IDX_W-1:0] MW  = IDX_W'(M);
    localparam logic [IDX_W-1:0] NW  = IDX_W'(N);
    localparam logic [IDX_W-1:0] PW  = IDX_W'(P);
    localparam logic [IDX_W-1:0] TJW = IDX_W'(TJ);
    localparam logic [IDX_W-1:0] TKW = IDX_W'(TK);

    // Index + step must never wrap, otherwise the loop-end compares would be wrong.
    if (M == 0 || N == 0 || P == 0 || TJ == 0 || TK == 0 ||
        (64'(M) + 64'(TJ)) >= (64'd1 << IDX_W) ||
        (64'(N) + 64'(TK)) >= (64'd1 << IDX_W) ||
        (64'(P) + 64'(TK)) >= (64'd1 << IDX_W)) begin : g_param_check
        $error("matmul_tile_sequencer: illegal dimensions or IDX_W too narrow");
    end

`ifdef MATMUL_SEQ_OVERLAP_EN
    typedef enum logic [2:0] {
        StIdle, StFetch, StMult, StAcc, StNext, StFin
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StFetchA, StFetchB, StMult, StAcc, StNext, StFin
    } state_e;
`endif

    state_e state_q, state_d;

    logic [IDX_W-1:0] row_q, col_q, red_q;
    logic [IDX_W-1:0] rows_v_q, cols_v_q, red_v_q, step_q;
    logic             fa_start_q, fb_start_q, mul_start_q, acc_start_q;

    logic [IDX_W-1:0] r_adv, l_adv, i_adv;
    logic [IDX_W-1:0] row_n, col_n, red_n;
    logic             r_wrap, l_wrap, i_wrap, last_step;

    // Valid extent of an edge tile: min(tile, limit - idx).
    function automatic logic [IDX_W-1:0] extent(input logic [IDX_W-1:0] lim,
                                                input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] tile);
        logic [IDX_W-1:0] rem;
        rem = lim - idx;
        return (rem < tile) ? rem : tile;
    endfunction

    // Loop-nest advance: r innermost, then l, then i.
    always_comb begin
        r_adv     = red_q + TKW;
        l_adv     = col_q + TKW;
        i_adv     = row_q + TJW;
        r_wrap    = !(r_adv < NW);
        l_wrap    = !(l_adv < PW);
        i_wrap    = !(i_adv < MW);
        last_step = r_wrap && l_wrap && i_wrap;
        red_n     = r_wrap ? '0 : r_adv;
        col_n     = r_wrap ? (l_wrap ? '0 : l_adv) : col_q;
        row_n     = (r_wrap && l_wrap) ? i_adv : row_q;
    end

`ifdef MATMUL_SEQ_OVERLAP_EN
    logic seen_a_q, seen_b_q;
    logic fetch_ok;

    // Both fetches complete once each strobe has been seen now or earlier in FETCH.
    always_comb begin
        fetch_ok = (seen_a_q || fa_done) && (seen_b_q || fb_done);
    end

    // Sticky done flags, cleared whenever FETCH is left (or not occupied).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_a_q <= 1'b0;
            seen_b_q <= 1'b0;
        end else if (state_q == StFetch && state_d == StFetch) begin
            seen_a_q <= seen_a_q || fa_done;
            seen_b_q <= seen_b_q || fb_done;
        end else begin
            seen_a_q <= 1'b0;
            seen_b_q <= 1'b0;
        end
    end
`endif

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
`ifdef MATMUL_SEQ_OVERLAP_EN
                if (start) state_d = StFetch;
`else
                if (start) state_d = StFetchA;
`endif
            end
`ifdef MATMUL_SEQ_OVERLAP_EN
            StFetch:  if (fetch_ok) state_d = StMult;
`else
            StFetchA: if (fa_done) state_d = StFetchB;
            StFetchB: if (fb_done) state_d = StMult;
`endif
            StMult:   if (mul_done) state_d = StAcc;
            StAcc:    if (acc_done) state_d = StNext;
`ifdef MATMUL_SEQ_OVERLAP_EN
            StNext:   state_d = last_step ? StFin : StFetch;
`else
            StNext:   state_d = last_step ? StFin : StFetchA;
`endif
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Unit start pulses: registered, high only in the first cycle of their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_start_q  <= 1'b0;
            fb_start_q  <= 1'b0;
            mul_start_q <= 1'b0;
            acc_start_q <= 1'b0;
        end else begin
`ifdef MATMUL_SEQ_OVERLAP_EN
            fa_start_q  <= (state_d == StFetch) && (state_q != StFetch);
            fb_start_q  <= (state_d == StFetch) && (state_q != StFetch);
`else
            fa_start_q  <= (state_d == StFetchA) && (state_q != StFetchA);
            fb_start_q  <= (state_d == StFetchB) && (state_q != StFetchB);
`endif
            mul_start_q <= (state_d == StMult) && (state_q != StMult);
            acc_start_q <= (state_d == StAcc) && (state_q != StAcc);
        end
    end

    // Tile indices, extents and step count; only touched on start and when leaving NEXT,
    // so they hold steady for a whole step and stay put after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            red_q    <= '0;
            rows_v_q <= '0;
            cols_v_q <= '0;
            red_v_q  <= '0;
            step_q   <= '0;
        end else if (state_q == StIdle && start) begin
            row_q    <= '0;
            col_q    <= '0;
            red_q    <= '0;
            rows_v_q <= extent(MW, '0, TJW);
            cols_v_q <= extent(PW, '0, TKW);
            red_v_q  <= extent(NW, '0, TKW);
            step_q   <= '0;
        end else if (state_q == StNext && !abort) begin
            step_q <= step_q + 1'b1;
            if (!last_step) begin
                row_q    <= row_n;
                col_q    <= col_n;
                red_q    <= red_n;
                rows_v_q <= extent(MW, row_n, TJW);
                cols_v_q <= extent(PW, col_n, TKW);
                red_v_q  <= extent(NW, red_n, TKW);
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StFin);
        done      = (state_q == StFin);
        acc_clear = busy && (red_q == '0);
        fa_start  = fa_start_q;
        fb_start  = fb_start_q;
        mul_start = mul_start_q;
        acc_start = acc_start_q;
        row_i     = row_q;
        col_l     = col_q;
        red_r     = red_q;
        rows_v    = rows_v_q;
        cols_v    = cols_v_q;
        red_v     = red_v_q;
        step_cnt  = step_q;
    end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: a 4x4x4 instance and a 5x3x4 instance,
// each with behavioural unit responders that return done a fixed latency after start.
module tb_matmul_tile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_start = 1'b0, b_start = 1'b0, a_abort = 1'b0;
    logic       a_busy, a_done, a_fa_start, a_fb_start, a_mul_start, a_acc_start, a_clr;
    logic       a_fa_done, a_fb_done, a_mul_done, a_acc_done;
    logic [9:0] a_row, a_red, a_col, a_rv, a_cv, a_dv, a_sc;
    logic       b_busy, b_done, b_fa_start, b_fb_start, b_mul_start, b_acc_start, b_clr;
    logic       b_fa_done, b_fb_done, b_mul_done, b_acc_done;
    logic [9:0] b_row, b_red, b_col, b_rv, b_cv, b_dv, b_sc;

    logic [7:0] st_vec;
    logic [7:0] dn_auto = '0;
    logic [7:0] dn_force = '0;
    int         cnt[8];
    int         lat = 3;
    bit         auto_en = 1'b1;

    int nvec = 0;
    int nerr = 0;
    int exp_i[16], exp_l[16], exp_r[16], exp_rv[16], exp_cv[16], exp_dv[16];

`ifdef MATMUL_SEQ_OVERLAP_EN
    localparam int StepLat3 = 13;
    localparam int StepLat0 = 4;
`else
    localparam int StepLat3 = 17;
    localparam int StepLat0 = 5;
`endif

    always #5 clk = ~clk;

    matmul_tile_sequencer #(.M(4), .N(4), .P(4), .TJ(2), .TK(2), .IDX_W(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done),
        .fa_start(a_fa_start), .fa_done(a_fa_done), .fb_start(a_fb_start), .fb_done(a_fb_done),
        .mul_start(a_mul_start), .mul_done(a_mul_done),
        .acc_start(a_acc_start), .acc_done(a_acc_done),
        .row_i(a_row), .red_r(a_red), .col_l(a_col), .rows_v(a_rv), .cols_v(a_cv),
        .red_v(a_dv), .acc_clear(a_clr), .step_cnt(a_sc)
    );

    matmul_tile_sequencer #(.M(5), .N(3), .P(4), .TJ(2), .TK(2), .IDX_W(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0),
        .busy(b_busy), .done(b_done),
        .fa_start(b_fa_start), .fa_done(b_fa_done), .fb_start(b_fb_start), .fb_done(b_fb_done),
        .mul_start(b_mul_start), .mul_done(b_mul_done),
        .acc_start(b_acc_start), .acc_done(b_acc_done),
        .row_i(b_row), .red_r(b_red), .col_l(b_col), .rows_v(b_rv), .cols_v(b_cv),
        .red_v(b_dv), .acc_clear(b_clr), .step_cnt(b_sc)
    );

    assign st_vec = {b_acc_start, b_mul_start, b_fb_start, b_fa_start,
                     a_acc_start, a_mul_start, a_fb_start, a_fa_start};
    assign {b_acc_done, b_mul_done, b_fb_done, b_fa_done,
            a_acc_done, a_mul_done, a_fb_done, a_fa_done} = dn_auto | dn_force;

    // Unit models: done strobe `lat` cycles after the start pulse (same cycle if lat==0).
    always @(negedge clk) begin
        for (int u = 0; u < 8; u++) begin
            dn_auto[u] = 1'b0;
            if (auto_en && st_vec[u]) begin
                if (lat == 0) dn_auto[u] = 1'b1;
                else          cnt[u] = lat;
            end else if (cnt[u] > 0) begin
                cnt[u] = cnt[u] - 1;
                if (cnt[u] == 0) dn_auto[u] = auto_en;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Fill expected tile table for a TJ=TK=2 nest over P=4 (two column tiles) and
    // a reduction of depth N (two reduction tiles; last one is 1 deep when N=3).
    task automatic fill_exp(input int n_red, input int m_rows);
        for (int k = 0; k < 16; k++) begin
            exp_i[k]  = (k / 4) * 2;
            exp_l[k]  = ((k / 2) % 2) * 2;
            exp_r[k]  = (k % 2) * 2;
            exp_rv[k] = (m_rows == 5 && exp_i[k] == 4) ? 1 : 2;
            exp_cv[k] = 2;
            exp_dv[k] = (n_red == 3 && exp_r[k] == 2) ? 1 : 2;
        end
    endtask

    // Start one full multiply and check every step's tile coordinates and the done pulse.
    task automatic run_check(input bit d2, input int nsteps, output int done_cyc);
        int k, step, dones;
        logic fa, dn, clr;
        logic [9:0] ri, cl, rr, rv, cv, dv, sc;
        k = 0; step = 0; dones = 0; done_cyc = -1;
        if (d2) b_start = 1'b1;
        else    a_start = 1'b1;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                a_start = 1'b0;
                b_start = 1'b0;
            end
            fa  = d2 ? b_fa_start : a_fa_start;
            dn  = d2 ? b_done : a_done;
            clr = d2 ? b_clr : a_clr;
            ri  = d2 ? b_row : a_row;
            cl  = d2 ? b_col : a_col;
            rr  = d2 ? b_red : a_red;
            rv  = d2 ? b_rv : a_rv;
            cv  = d2 ? b_cv : a_cv;
            dv  = d2 ? b_dv : a_dv;
            sc  = d2 ? b_sc : a_sc;
            if (fa) begin
                if (step < nsteps) begin
                    check("row_i", ri, exp_i[step]);
                    check("col_l", cl, exp_l[step]);
                    check("red_r", rr, exp_r[step]);
                    check("rows_v", rv, exp_rv[step]);
                    check("cols_v", cv, exp_cv[step]);
                    check("red_v", dv, exp_dv[step]);
                    check("acc_clear", clr, (exp_r[step] == 0) ? 1 : 0);
                    check("step_cnt_in_step", sc, step);
                end
                step++;
            end
            if (dn) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    check("step_cnt_at_done", sc, nsteps);
                end
            end
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
        end
        check("steps_issued", step, nsteps);
        check("done_pulses", dones, 1);
    endtask

    initial begin
        int dc, nfa, extra;
        bit hit;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_fa_start", a_fa_start, 0);
        check("rst_mul_start", a_mul_start, 0);
        check("rst_row_i", a_row, 0);
        check("rst_rows_v", a_rv, 0);
        check("rst_step_cnt", a_sc, 0);
        check("rst_acc_clear", a_clr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4x4, latency 3 then latency 0
        fill_exp(4, 4);
        lat = 3;
        run_check(1'b0, 8, dc);
        check("a_lat3_done_cycle", dc, StepLat3 * 8 + 1);
        lat = 0;
        run_check(1'b0, 8, dc);
        check("a_lat0_done_cycle", dc, StepLat0 * 8 + 1);

        // 5x3x4 edge tiles
        fill_exp(3, 5);
        lat = 3;
        run_check(1'b1, 12, dc);
        check("b_lat3_done_cycle", dc, StepLat3 * 12 + 1);
        lat = 0;
        run_check(1'b1, 12, dc);
        check("b_lat0_done_cycle", dc, StepLat0 * 12 + 1);

        // Stray mul_done in the fetch state and repeated start while busy
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        check("man_fa_start", a_fa_start, 1);
`ifdef MATMUL_SEQ_OVERLAP_EN
        check("man_fb_start_with_fa", a_fb_start, 1);
`else
        check("man_fb_start_with_fa", a_fb_start, 0);
`endif
        dn_force[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("stray_fa_start", a_fa_start, 0);
            check("stray_fb_start", a_fb_start, 0);
            check("stray_mul_start", a_mul_start, 0);
            check("stray_busy", a_busy, 1);
        end
        a_start = 1'b0;
        dn_force = 8'b0000_0011;
        @(negedge clk);
        dn_force = '0;
`ifdef MATMUL_SEQ_OVERLAP_EN
        check("fetch_then_mul_start", a_mul_start, 1);
`else
        check("fa_then_fb_start", a_fb_start, 1);
        check("fa_then_no_mul", a_mul_start, 0);
`endif
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("man_abort_busy", a_busy, 0);

`ifdef MATMUL_SEQ_OVERLAP_EN
        // fb_done two cycles before fa_done
        repeat (2) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("ov_fa_start", a_fa_start, 1);
        check("ov_fb_start", a_fb_start, 1);
        @(negedge clk);
        dn_force[1] = 1'b1;
        check("ov_c2_mul", a_mul_start, 0);
        @(negedge clk);
        dn_force = '0;
        check("ov_c3_mul", a_mul_start, 0);
        @(negedge clk);
        dn_force[0] = 1'b1;
        check("ov_c4_mul", a_mul_start, 0);
        @(negedge clk);
        dn_force = '0;
        check("ov_c5_mul", a_mul_start, 1);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        // Both dones in the same cycle
        repeat (2) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("ov2_both_start", {a_fa_start, a_fb_start}, 2'b11);
        @(negedge clk);
        dn_force = 8'b0000_0011;
        check("ov2_c2_mul", a_mul_start, 0);
        @(negedge clk);
        dn_force = '0;
        check("ov2_c3_mul", a_mul_start, 1);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
`endif

        // Abort in MULT of step 3, then restart
        auto_en = 1'b1;
        lat = 3;
        repeat (6) @(negedge clk);
        nfa = 0;
        hit = 1'b0;
        a_start = 1'b1;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (c == 0) a_start = 1'b0;
            if (a_fa_start) nfa++;
            if (nfa == 3 && a_mul_start) begin
                hit = 1'b1;
                a_abort = 1'b1;
            end
        end
        check("abort_point_reached", hit, 1);
        @(negedge clk);
        a_abort = 1'b0;
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_done || a_busy || a_fa_start || a_fb_start || a_mul_start || a_acc_start)
                extra++;
        end
        check("post_abort_activity", extra, 0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("restart_fa_start", a_fa_start, 1);
        check("restart_row_i", a_row, 0);
        check("restart_col_l", a_col, 0);
        check("restart_red_r", a_red, 0);
        check("restart_step_cnt", a_sc, 0);
        check("restart_busy", a_busy, 1);

        // Asynchronous reset mid-operation (run reaches the second column tile first)
        repeat (40) @(negedge clk);
        check("pre_reset_col_l", a_col, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", a_busy, 0);
        check("async_rst_col_l", a_col, 0);
        check("async_rst_step_cnt", a_sc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("after_rst_idle", a_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
